// File: rtl/bf_radix2_pipe.sv
// Radix-2 decimation-in-frequency butterfly, three pipeline stages.
//   Y0 = A + B
//   Y1 = (A - B) * W
// Data are signed fixed point with FRAC_W fractional bits. Each output set
// carries its own scale_en / round_mode through the pipe. A single global
// advance enable stalls every stage while the output is held.
module bf_radix2_pipe #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] A_re,
    input  logic [DATA_W-1:0] A_im,
    input  logic [DATA_W-1:0] B_re,
    input  logic [DATA_W-1:0] B_im,
    input  logic [DATA_W-1:0] W_re,
    input  logic [DATA_W-1:0] W_im,
    input  logic              scale_en,
    input  logic              round_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] Y0_re,
    output logic [DATA_W-1:0] Y0_im,
    output logic [DATA_W-1:0] Y1_re,
    output logic [DATA_W-1:0] Y1_im,
    output logic              ovf,
    input  logic              ovf_clr
);

    // Sum/difference width, product width, combine width, shift-count width.
    localparam int SW  = DATA_W + 1;
    localparam int PW  = 2 * DATA_W + 2;
    localparam int CW  = 2 * DATA_W + 3;
    localparam int SHW = $clog2(DATA_W + 1);

    // Saturation bounds expressed at combine width.
    localparam logic signed [CW-1:0] SAT_MAX = {{(CW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [CW-1:0] SAT_MIN = {{(CW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Shift right by s with the selected rounding.
    //   mode 0: toward zero (floor shift, then +1 for negatives that lost bits)
    //   mode 1: half up, floor((v + 2^(s-1)) / 2^s); s = 0 passes through
    function automatic logic signed [CW-1:0] round_shift(
        input logic signed [CW-1:0] v,
        input logic [SHW-1:0]       s,
        input logic                 mode
    );
        logic signed [CW-1:0] one_v;
        logic signed [CW-1:0] mask_v;
        logic signed [CW-1:0] half_v;
        logic signed [CW-1:0] q_v;
        one_v  = {{(CW-1){1'b0}}, 1'b1};
        mask_v = (one_v <<< s) - one_v;
        half_v = '0;
        if (mode) begin
            if (s == '0) begin
                q_v = v;
            end else begin
                half_v = one_v <<< (s - SHW'(1));
                q_v    = (v + half_v) >>> s;
            end
        end else begin
            q_v = v >>> s;
            if (v[CW-1] && ((v & mask_v) != '0)) begin
                q_v = q_v + one_v;
            end
        end
        return q_v;
    endfunction

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic stall;
    logic adv;
    logic out_valid_q;
    logic ovf_q;
    logic ovf_d;

    assign stall    = out_valid_q & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = ~stall;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic                 s1_valid_q,  s1_valid_d;
    logic signed [SW-1:0] s1_sum_re_q, s1_sum_re_d;
    logic signed [SW-1:0] s1_sum_im_q, s1_sum_im_d;
    logic signed [SW-1:0] s1_dif_re_q, s1_dif_re_d;
    logic signed [SW-1:0] s1_dif_im_q, s1_dif_im_d;
    logic [DATA_W-1:0]    s1_w_re_q,   s1_w_re_d;
    logic [DATA_W-1:0]    s1_w_im_q,   s1_w_im_d;
    logic                 s1_scale_q,  s1_scale_d;
    logic                 s1_rmode_q,  s1_rmode_d;

    logic                 s2_valid_q,  s2_valid_d;
    logic signed [SW-1:0] s2_sum_re_q, s2_sum_re_d;
    logic signed [SW-1:0] s2_sum_im_q, s2_sum_im_d;
    logic signed [PW-1:0] s2_p_rr_q,   s2_p_rr_d;
    logic signed [PW-1:0] s2_p_ii_q,   s2_p_ii_d;
    logic signed [PW-1:0] s2_p_ri_q,   s2_p_ri_d;
    logic signed [PW-1:0] s2_p_ir_q,   s2_p_ir_d;
    logic                 s2_scale_q,  s2_scale_d;
    logic                 s2_rmode_q,  s2_rmode_d;

    logic                 out_valid_d;
    logic [DATA_W-1:0]    y_q [4];
    logic [DATA_W-1:0]    y_d [4];
    logic                 lane_sat [4];
    logic                 sat_any;

    // Stage 1: widen by one bit so A+B and A-B can never wrap.
    always_comb begin
        s1_valid_d  = in_valid;
        s1_sum_re_d = $signed({A_re[DATA_W-1], A_re}) + $signed({B_re[DATA_W-1], B_re});
        s1_sum_im_d = $signed({A_im[DATA_W-1], A_im}) + $signed({B_im[DATA_W-1], B_im});
        s1_dif_re_d = $signed({A_re[DATA_W-1], A_re}) - $signed({B_re[DATA_W-1], B_re});
        s1_dif_im_d = $signed({A_im[DATA_W-1], A_im}) - $signed({B_im[DATA_W-1], B_im});
        s1_w_re_d   = W_re;
        s1_w_im_d   = W_im;
        s1_scale_d  = scale_en;
        s1_rmode_d  = round_mode;
    end

    // Stage 2: the four real partial products of (A-B)*W at full precision.
    logic signed [PW-1:0] xr_x, xi_x, wr_x, wi_x;
    always_comb begin
        xr_x        = {{(PW-SW){s1_dif_re_q[SW-1]}}, s1_dif_re_q};
        xi_x        = {{(PW-SW){s1_dif_im_q[SW-1]}}, s1_dif_im_q};
        wr_x        = {{(PW-DATA_W){s1_w_re_q[DATA_W-1]}}, s1_w_re_q};
        wi_x        = {{(PW-DATA_W){s1_w_im_q[DATA_W-1]}}, s1_w_im_q};
        s2_valid_d  = s1_valid_q;
        s2_sum_re_d = s1_sum_re_q;
        s2_sum_im_d = s1_sum_im_q;
        s2_p_rr_d   = xr_x * wr_x;
        s2_p_ii_d   = xi_x * wi_x;
        s2_p_ri_d   = xr_x * wi_x;
        s2_p_ir_d   = xi_x * wr_x;
        s2_scale_d  = s1_scale_q;
        s2_rmode_d  = s1_rmode_q;
    end

    // Stage 3 prep: combine partial products before the single rounding step.
    logic signed [CW-1:0] full_v [4];
    logic [SHW-1:0]       sh0;
    logic [SHW-1:0]       sh1;
    always_comb begin
        full_v[0] = {{(CW-SW){s2_sum_re_q[SW-1]}}, s2_sum_re_q};
        full_v[1] = {{(CW-SW){s2_sum_im_q[SW-1]}}, s2_sum_im_q};
        full_v[2] = {s2_p_rr_q[PW-1], s2_p_rr_q} - {s2_p_ii_q[PW-1], s2_p_ii_q};
        full_v[3] = {s2_p_ri_q[PW-1], s2_p_ri_q} + {s2_p_ir_q[PW-1], s2_p_ir_q};
        sh0       = {{(SHW-1){1'b0}}, s2_scale_q};
        sh1       = SHW'(FRAC_W) + sh0;
    end

    // Lanes 0/1 are Y0 (shift by scale only), lanes 2/3 are Y1 (also drop FRAC_W).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam bit IS_Y1 = (gi >= 2);
            logic [SHW-1:0]       lane_sh;
            logic signed [CW-1:0] lane_rnd;
            logic [DATA_W-1:0]    lane_y;
            logic                 lane_s;

            // Round, then clamp into the output range.
            always_comb begin
                lane_sh  = IS_Y1 ? sh1 : sh0;
                lane_rnd = round_shift(full_v[gi], lane_sh, s2_rmode_q);
                lane_s   = 1'b0;
                lane_y   = lane_rnd[DATA_W-1:0];
                if (lane_rnd > SAT_MAX) begin
                    lane_y = SAT_MAX[DATA_W-1:0];
                    lane_s = 1'b1;
                end else if (lane_rnd < SAT_MIN) begin
                    lane_y = SAT_MIN[DATA_W-1:0];
                    lane_s = 1'b1;
                end
            end

            assign y_d[gi]      = lane_y;
            assign lane_sat[gi] = lane_s;
        end
    endgenerate

    assign sat_any     = lane_sat[0] | lane_sat[1] | lane_sat[2] | lane_sat[3];
    assign out_valid_d = s2_valid_q;

    // Sticky flag: a saturating set loaded into the output wins over a clear.
    assign ovf_d = (ovf_q & ~ovf_clr) | (adv & s2_valid_q & sat_any);

    // Pipeline registers: everything advances together or holds together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sum_re_q <= '0;
            s1_sum_im_q <= '0;
            s1_dif_re_q <= '0;
            s1_dif_im_q <= '0;
            s1_w_re_q   <= '0;
            s1_w_im_q   <= '0;
            s1_scale_q  <= 1'b0;
            s1_rmode_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_sum_re_q <= '0;
            s2_sum_im_q <= '0;
            s2_p_rr_q   <= '0;
            s2_p_ii_q   <= '0;
            s2_p_ri_q   <= '0;
            s2_p_ir_q   <= '0;
            s2_scale_q  <= 1'b0;
            s2_rmode_q  <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                y_q[i] <= '0;
            end
        end else if (adv) begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_re_q <= s1_sum_re_d;
            s1_sum_im_q <= s1_sum_im_d;
            s1_dif_re_q <= s1_dif_re_d;
            s1_dif_im_q <= s1_dif_im_d;
            s1_w_re_q   <= s1_w_re_d;
            s1_w_im_q   <= s1_w_im_d;
            s1_scale_q  <= s1_scale_d;
            s1_rmode_q  <= s1_rmode_d;
            s2_valid_q  <= s2_valid_d;
            s2_sum_re_q <= s2_sum_re_d;
            s2_sum_im_q <= s2_sum_im_d;
            s2_p_rr_q   <= s2_p_rr_d;
            s2_p_ii_q   <= s2_p_ii_d;
            s2_p_ri_q   <= s2_p_ri_d;
            s2_p_ir_q   <= s2_p_ir_d;
            s2_scale_q  <= s2_scale_d;
            s2_rmode_q  <= s2_rmode_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < 4; i++) begin
                y_q[i] <= y_d[i];
            end
        end
    end

    // Overflow flag register; clear works even while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    assign Y0_re     = y_q[0];
    assign Y0_im     = y_q[1];
    assign Y1_re     = y_q[2];
    assign Y1_im     = y_q[3];

endmodule

// File: tb/tb_bf_radix2_pipe.sv
// Self-checking bench for bf_radix2_pipe (DATA_W=16, FRAC_W=8).
// Expected results come from plain integer arithmetic on the operand set;
// a three-slot latency model supplies expected valid/ready/ovf timing.
module tb_bf_radix2_pipe;

    localparam int DW = 16;
    localparam int FW = 8;

    typedef struct packed {
        logic [15:0] ar, ai, br, bi, wr, wi;
        logic        sc, rm;
    } op_t;

    typedef struct packed {
        logic [15:0] y0r, y0i, y1r, y1i;
        logic        sat;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [15:0] A_re = '0, A_im = '0, B_re = '0, B_im = '0, W_re = '0, W_im = '0;
    logic scale_en = 1'b0, round_mode = 1'b0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [15:0] Y0_re, Y0_im, Y1_re, Y1_im;
    logic ovf;
    logic ovf_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;

    bf_radix2_pipe #(.DATA_W(DW), .FRAC_W(FW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A_re(A_re), .A_im(A_im), .B_re(B_re), .B_im(B_im),
        .W_re(W_re), .W_im(W_im), .scale_en(scale_en), .round_mode(round_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .Y0_re(Y0_re), .Y0_im(Y0_im), .Y1_re(Y1_re), .Y1_im(Y1_im),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic longint rnd(input longint v, input int s, input bit m);
        longint p;
        p = longint'(1) <<< s;
        if (m) begin
            if (s == 0) return v;
            return (v + p / 2) >>> s;
        end
        return v / p;
    endfunction

    function automatic longint clamp(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic bit oor(input longint v);
        return (v > 32767) || (v < -32768);
    endfunction

    function automatic res_t ref_bf(input op_t o);
        longint ar, ai, br, bi, wr, wi, xr, xi, v0r, v0i, v1r, v1i;
        int s0, s1;
        res_t r;
        ar = longint'($signed(o.ar)); ai = longint'($signed(o.ai));
        br = longint'($signed(o.br)); bi = longint'($signed(o.bi));
        wr = longint'($signed(o.wr)); wi = longint'($signed(o.wi));
        xr = ar - br; xi = ai - bi;
        s0 = int'(o.sc); s1 = FW + int'(o.sc);
        v0r = rnd(ar + br, s0, o.rm);
        v0i = rnd(ai + bi, s0, o.rm);
        v1r = rnd(xr * wr - xi * wi, s1, o.rm);
        v1i = rnd(xr * wi + xi * wr, s1, o.rm);
        r.y0r = 16'(clamp(v0r)); r.y0i = 16'(clamp(v0i));
        r.y1r = 16'(clamp(v1r)); r.y1i = 16'(clamp(v1i));
        r.sat = oor(v0r) || oor(v0i) || oor(v1r) || oor(v1i);
        return r;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- timing model ----------------
    res_t m_set [3];
    bit   m_v   [3];
    bit   m_ovf;
    op_t  cur_op;

    assign cur_op = '{ar: A_re, ai: A_im, br: B_re, bi: B_im, wr: W_re, wi: W_im,
                      sc: scale_en, rm: round_mode};

    // Accepted sets age one slot per non-stalled cycle; slot 2 is the output.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_v[0] <= 1'b0; m_v[1] <= 1'b0; m_v[2] <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (!(m_v[2] && !out_ready)) begin
            m_v[2]   <= m_v[1];   m_set[2] <= m_set[1];
            m_v[1]   <= m_v[0];   m_set[1] <= m_set[0];
            m_v[0]   <= in_valid; m_set[0] <= ref_bf(cur_op);
            m_ovf    <= (m_ovf && !ovf_clr) || (m_v[1] && m_set[1].sat);
        end else begin
            m_ovf <= m_ovf && !ovf_clr;
        end
    end

    // Output handshake counter.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) n_out <= n_out + 1;
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("out_valid", out_valid, m_v[2]);
        chk("in_ready", in_ready, !(m_v[2] && !out_ready));
        chk("ovf", ovf, m_ovf);
        if (m_v[2] && out_valid) begin
            chk("Y0_re", Y0_re, m_set[2].y0r);
            chk("Y0_im", Y0_im, m_set[2].y0i);
            chk("Y1_re", Y1_re, m_set[2].y1r);
            chk("Y1_im", Y1_im, m_set[2].y1i);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic apply(input op_t o);
        A_re = o.ar; A_im = o.ai; B_re = o.br; B_im = o.bi;
        W_re = o.wr; W_im = o.wi; scale_en = o.sc; round_mode = o.rm;
    endtask

    function automatic logic [15:0] rval();
        logic [31:0] v;
        v = $urandom;
        if (v[31]) return {{6{v[9]}}, v[9:0]};
        return v[15:0];
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.ar = rval(); o.ai = rval(); o.br = rval(); o.bi = rval();
        o.wr = rval(); o.wi = rval();
        o.sc = 1'($urandom_range(0, 1)); o.rm = 1'($urandom_range(0, 1));
        return o;
    endfunction

    // One isolated set against literal expectations; checks 3-cycle latency.
    task automatic dir_test(input string nm, input op_t o, input logic [15:0] e0r,
                            input logic [15:0] e0i, input logic [15:0] e1r,
                            input logic [15:0] e1i);
        res_t r;
        int cyc;
        r = ref_bf(o);
        chk({nm, "_model_y0r"}, r.y0r, e0r);
        chk({nm, "_model_y1r"}, r.y1r, e1r);
        @(posedge clk); #1;
        apply(o); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 10);
        chk({nm, "_latency"}, cyc, 3);
        chk({nm, "_Y0_re"}, Y0_re, e0r);
        chk({nm, "_Y0_im"}, Y0_im, e0i);
        chk({nm, "_Y1_re"}, Y1_re, e1r);
        chk({nm, "_Y1_im"}, Y1_im, e1i);
        $display("[TB] %s: Y0=(%h,%h) Y1=(%h,%h) ovf=%0b lat=%0d",
                 nm, Y0_re, Y0_im, Y1_re, Y1_im, ovf, cyc);
    endtask

    // Present a set and hold it until the handshake happens.
    task automatic send_hs(input op_t o);
        bit acc;
        int k;
        apply(o); in_valid = 1'b1;
        acc = 1'b0; k = 0;
        while (!acc && k < 50) begin
            @(negedge clk); #2;
            acc = in_ready;
            @(posedge clk); #1;
            k++;
        end
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        op_t o;
        int base, k;

        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ovf", ovf, 0);
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;

        o = '{ar: 16'h0100, ai: 16'h0000, br: 16'h0080, bi: 16'h0000,
              wr: 16'h0100, wi: 16'h0000, sc: 1'b0, rm: 1'b0};
        dir_test("basic", o, 16'h0180, 16'h0000, 16'h0080, 16'h0000);
        chk("basic_ovf", ovf, 0);
        o.sc = 1'b1;
        dir_test("basic_scaled", o, 16'h00C0, 16'h0000, 16'h0040, 16'h0000);

        o = '{ar: 16'h0100, ai: 16'h0200, br: 16'h0000, bi: 16'h0000,
              wr: 16'h0000, wi: 16'hFF00, sc: 1'b0, rm: 1'b0};
        dir_test("twiddle_mj", o, 16'h0100, 16'h0200, 16'h0200, 16'hFF00);

        o = '{ar: 16'h0000, ai: 16'h0000, br: 16'h0001, bi: 16'h0000,
              wr: 16'h00C0, wi: 16'h0000, sc: 1'b0, rm: 1'b0};
        dir_test("round_trunc", o, 16'h0001, 16'h0000, 16'h0000, 16'h0000);
        o.rm = 1'b1;
        dir_test("round_half_up", o, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000);

        o = '{ar: 16'h7F00, ai: 16'h0000, br: 16'h7F00, bi: 16'h0000,
              wr: 16'h0100, wi: 16'h0000, sc: 1'b0, rm: 1'b0};
        dir_test("sat", o, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
        chk("sat_ovf_set", ovf, 1);
        repeat (3) @(negedge clk);
        chk("sat_ovf_sticky", ovf, 1);
        o.sc = 1'b1;
        dir_test("sat_scaled", o, 16'h7F00, 16'h0000, 16'h0000, 16'h0000);
        chk("sat_scaled_ovf_held", ovf, 1);
        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", ovf, 0);

        // Back-to-back stream with a 4-cycle output stall on the third result.
        base = n_out;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 8; i++) send_hs(rand_op());
                in_valid = 1'b0;
            end
            begin
                k = 0;
                while (n_out < base + 2 && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                if (k >= 100) chk("stall_wait", 0, 1);
                #1 out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_in_ready", in_ready, 0);
                end
                #1 out_ready = 1'b1;
            end
        join
        k = 0;
        while (n_out < base + 8 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("stream_count", n_out - base, 8);
        repeat (4) @(negedge clk);
        chk("stream_no_extra", n_out - base, 8);
        $display("[TB] stream: %0d results delivered", n_out - base);

        // Randomized traffic with random back-pressure and clears.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            apply(rand_op());
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        repeat (6) @(posedge clk);
        $display("[TB] random: %0d results delivered", n_out - base - 8);

        // Reset with two sets in flight.
        @(posedge clk); #1;
        apply(rand_op()); in_valid = 1'b1;
        @(posedge clk); #1;
        apply(rand_op());
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("postrst_no_valid", out_valid, 0);
        end
        o = '{ar: 16'h0100, ai: 16'h0000, br: 16'h0080, bi: 16'h0000,
              wr: 16'h0100, wi: 16'h0000, sc: 1'b0, rm: 1'b0};
        dir_test("after_reset", o, 16'h0180, 16'h0000, 16'h0080, 16'h0000);
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bf_radix2_pipe.md
BF_RADIX2_PIPE -- requirements
Module: bf_radix2_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed two's-complement width of every data and twiddle component.
REQ-002 SHALL have parameter FRAC_W, default 8: fractional bits of the fixed-point format (Q(DATA_W-FRAC_W-1).FRAC_W); legal range 1..DATA_W-2.
REQ-003 SHALL have ports (name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous, active-high reset
  in_valid  in  1  input operand set valid
  in_ready  out  1  block accepts operands this cycle
  A_re, A_im, B_re, B_im  in  DATA_W  butterfly inputs A, B
  W_re, W_im  in  DATA_W  twiddle factor
  scale_en  in  1  sampled with operands; 1 = divide both outputs by 2
  round_mode  in  1  sampled with operands; 0 = truncate toward zero, 1 = round half up
  out_valid  out  1  output set valid
  out_ready  in  1  downstream accepts outputs
  Y0_re, Y0_im, Y1_re, Y1_im  out  DATA_W  butterfly outputs
  ovf  out  1  sticky saturation flag
  ovf_clr  in  1  synchronous clear of ovf

Function
REQ-004 SHALL compute Y0 = A + B and Y1 = (A - B) * W, complex, with Y1_re = Xre*Wre - Xim*Wim and Y1_im = Xre*Wim + Xim*Wre.
REQ-005 SHALL form sums and differences at DATA_W+1 bits and products at 2*DATA_W+2 bits; no intermediate truncation or wrap.
REQ-006 SHALL combine the two Y1 partial products at full precision, then apply exactly one rounding step (no per-product rounding).
REQ-007 SHALL use right shift S = FRAC_W + scale_en for Y1 and S = scale_en for Y0.
REQ-008 round_mode=0: result = full-precision value shifted right by S, rounded toward zero (negative values with nonzero discarded bits get +1 after the arithmetic shift).
REQ-009 round_mode=1: result = floor((value + 2^(S-1)) / 2^S); when S=0 the value passes through unchanged.
REQ-010 SHALL saturate each rounded component to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-011 SHALL set ovf on the cycle any component of an output set presented with out_valid=1 saturates; ovf holds until ovf_clr.
REQ-012 When ovf_clr and a new saturation event occur in the same cycle, ovf SHALL end the cycle at 1.
REQ-013 SHALL be a 3-stage pipeline: stage 1 sum/difference; stage 2 four products; stage 3 combine, round, saturate, register outputs.
REQ-014 With no stall, latency from an accepted input (in_valid & in_ready) to out_valid SHALL be exactly 3 cycles; throughput is one set per cycle.
REQ-015 scale_en and round_mode SHALL travel with their operand set through the pipeline.
REQ-016 SHALL define stall = out_valid & ~out_ready; in_ready = ~stall.
REQ-017 During stall all pipeline registers, including valid bits and outputs, SHALL hold.
REQ-018 in_valid while in_ready=0 SHALL be ignored, with no state change.
REQ-019 Bubbles (in_valid=0) SHALL propagate as invalid stages.
REQ-020 Output data while out_valid=0 SHALL be don't-care for the bench.

Reset
REQ-021 rst=1 SHALL asynchronously clear all stage valid bits, out_valid, ovf and all data registers to 0.
REQ-022 in_ready SHALL read 1 during reset.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight sets; no out_valid pulse SHALL arise from them after release.
REQ-024 The first input accepted after release SHALL emerge after exactly 3 cycles.

Verification (DATA_W=16, FRAC_W=8; all values hex)
REQ-025 A=(0100,0), B=(0080,0), W=(0100,0), scale_en=0 -> 3 cycles later Y0=(0180,0), Y1=(0080,0), ovf=0; with scale_en=1 -> Y0=(00C0,0), Y1=(0040,0).
REQ-026 A=(0100,0200), B=(0,0), W=(0000,FF00) (-j) -> Y1=(0200,FF00).
REQ-027 A=(7F00,0), B=(7F00,0), scale_en=0 -> Y0_re=7FFF, ovf=1 and stays 1 until ovf_clr pulse; same operands with scale_en=1 -> Y0_re=7F00, ovf unchanged.
REQ-028 A=(0,0), B=(0001,0), W=(00C0,0) -> round_mode=0 gives Y1_re=0000; round_mode=1 gives Y1_re=FFFF.
REQ-029 Stream 8 back-to-back sets; hold out_ready=0 for 4 cycles at set 3 -> outputs held stable, in_ready=0 during the stall, all 8 results in order, none lost or duplicated.
REQ-030 Assert rst with 2 sets in flight -> out_valid=0 immediately and stays 0 until a new set is accepted, which appears 3 cycles after acceptance.
